// File: rtl/sipo_deserializer.sv
// -----------------------------------------------------------------------------
// sipo_deserializer
//   Serial-in/parallel-out deserializer. It accepts one bit per clock while SE
//   is high. When a word is complete, the word is copied to PO and PO_VALID
//   pulses for one cycle. BIT_CNT tracks word alignment.
//
//   Optional macro SIPO_DESER_PARITY_EN:
//     - Each frame carries WIDTH data bits plus one even-parity bit.
//     - The parity bit is checked but never enters SR.
//     - PAR_ERR is flagged together with PO_VALID.
//
// Parameters:
//   WIDTH      word width, 2..32
//   MSB_FIRST  1: first bit received lands in PO[WIDTH-1]; 0: lands in PO[0]
//
// Ports:
//   CLK       rising-edge clock
//   CLR_N     asynchronous active-low reset
//   SI        serial data, sampled only when SE=1
//   SE        shift enable
//   SCLR      synchronous restart, discards any partial word
//   SR        live shift register
//   PO        last completed word (held)
//   PO_VALID  one-cycle strobe when PO updates
//   BUSY      partial word in progress (BIT_CNT != 0)
//   BIT_CNT   bits of the current frame received so far
//   PAR_ERR   (parity build only) parity mismatch, valid with PO_VALID
// -----------------------------------------------------------------------------
module sipo_deserializer #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1,
`ifdef SIPO_DESER_PARITY_EN
   localparam int LAST     = WIDTH,      // extra parity slot ends the frame
`else
   localparam int LAST     = WIDTH - 1,
`endif
   localparam int CW       = $clog2(LAST + 1)
) (
   input  logic             CLK,
   input  logic             CLR_N,
   input  logic             SI,
   input  logic             SE,
   input  logic             SCLR,
   output logic [WIDTH-1:0] SR,
   output logic [WIDTH-1:0] PO,
   output logic             PO_VALID,
   output logic             BUSY,
   output logic [CW-1:0]    BIT_CNT
`ifdef SIPO_DESER_PARITY_EN
   ,
   output logic             PAR_ERR
`endif
);

   localparam logic [CW-1:0] LAST_CNT = CW'(LAST);

   logic [WIDTH-1:0] sr_next;
   logic             data_bit;

   // Direction of the shift is fixed at elaboration time.
   always_comb begin
      if (MSB_FIRST) sr_next = {SR[WIDTH-2:0], SI};
      else           sr_next = {SI, SR[WIDTH-1:1]};
   end

`ifdef SIPO_DESER_PARITY_EN
   // The parity slot (count == WIDTH) is consumed without touching SR.
   assign data_bit = (BIT_CNT != LAST_CNT);
`else
   assign data_bit = 1'b1;
`endif

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         SR       <= '0;
         PO       <= '0;
         PO_VALID <= 1'b0;
         BUSY     <= 1'b0;
         BIT_CNT  <= '0;
`ifdef SIPO_DESER_PARITY_EN
         PAR_ERR  <= 1'b0;
`endif
      end else if (SCLR) begin
         SR       <= '0;
         PO_VALID <= 1'b0;
         BUSY     <= 1'b0;
         BIT_CNT  <= '0;
`ifdef SIPO_DESER_PARITY_EN
         PAR_ERR  <= 1'b0;
`endif
      end else if (SE) begin
         if (data_bit) SR <= sr_next;
         if (BIT_CNT == LAST_CNT) begin
`ifdef SIPO_DESER_PARITY_EN
            // SR already holds the full data word; SI is the parity bit.
            PO      <= SR;
            PAR_ERR <= (^SR) ^ SI;
`else
            PO      <= sr_next;
`endif
            PO_VALID <= 1'b1;
            BUSY     <= 1'b0;
            BIT_CNT  <= '0;
         end else begin
            PO_VALID <= 1'b0;
            BUSY     <= 1'b1;
            BIT_CNT  <= BIT_CNT + CW'(1);
`ifdef SIPO_DESER_PARITY_EN
            PAR_ERR  <= 1'b0;
`endif
         end
      end else begin
         PO_VALID <= 1'b0;
`ifdef SIPO_DESER_PARITY_EN
         PAR_ERR  <= 1'b0;
`endif
      end
   end

endmodule
